div_seq_ctrl: RTL and testbench



---
 rtl/div_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_div_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the EX-stage divide/modulo datapath: issues operands to the
// external divider cores, captures the selected quotient/remainder and swallows killed results.
module div_seq_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        req_ready,
    input  logic        flush,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ack,
    output logic        busy,
    output logic        dvd_tvalid,
    input  logic        dvd_tready,
    output logic        dvs_tvalid,
    input  logic        dvs_tready,
    output logic [31:0] dvd_tdata,
    output logic [31:0] dvs_tdata,
    output logic        div_unsigned,
    input  logic        dout_tvalid,
    input  logic [63:0] dout_tdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  op_q, op_d;
    logic        dvd_done_q, dvd_done_d;
    logic        dvs_done_q, dvs_done_d;
    logic        kill_q, kill_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            src1_q     <= 32'd0;
            src2_q     <= 32'd0;
            res_q      <= 32'd0;
            op_q       <= 2'd0;
            dvd_done_q <= 1'b0;
            dvs_done_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            res_q      <= res_d;
            op_q       <= op_d;
            dvd_done_q <= dvd_done_d;
            dvs_done_q <= dvs_done_d;
            kill_q     <= kill_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d    = state_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        res_d      = res_q;
        op_d       = op_q;
        dvd_done_d = dvd_done_q;
        dvs_done_d = dvs_done_q;
        kill_d     = kill_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    src1_d     = req_src1;
                    src2_d     = req_src2;
                    op_d       = req_op;
                    dvd_done_d = 1'b0;
                    dvs_done_d = 1'b0;
                    kill_d     = 1'b0;
                    state_d    = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // A flush cannot withdraw an offered operand, so it only marks the result for discard.
                dvd_done_d = dvd_done_q | (dvd_tvalid & dvd_tready);
                dvs_done_d = dvs_done_q | (dvs_tvalid & dvs_tready);
                kill_d     = kill_q | flush;
                if (dvd_done_d && dvs_done_d) begin
                    state_d = kill_d ? S_DRAIN : S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = dout_tvalid ? S_IDLE : S_DRAIN;
                end else if (dout_tvalid) begin
                    res_d   = op_q[0] ? dout_tdata[31:0] : dout_tdata[63:32];
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (res_ack || flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (dout_tvalid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign res_valid    = (state_q == S_DONE);
    assign res_data     = res_q;
    assign dvd_tvalid   = (state_q == S_ISSUE) && !dvd_done_q;
    assign dvs_tvalid   = (state_q == S_ISSUE) && !dvs_done_q;
    assign dvd_tdata    = src1_q;
    assign dvs_tdata    = src2_q;
    assign div_unsigned = busy & op_q[1];

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized self-checking bench for div_seq_ctrl with a behavioural divider-core model.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn, req_valid, flush, res_ack;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        req_ready, res_valid, busy;
    logic [31:0] res_data;
    logic        dvd_tvalid, dvd_tready, dvs_tvalid, dvs_tready, div_unsigned;
    logic [31:0] dvd_tdata, dvs_tdata;
    logic        dout_tvalid;
    logic [63:0] dout_tdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic        have_a, have_b, core_u;
    logic [31:0] core_a, core_b;
    logic [63:0] core_res;
    int          core_cnt, core_lat, rdy_mode;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    div_seq_ctrl dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready), .flush(flush),
        .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack), .busy(busy),
        .dvd_tvalid(dvd_tvalid), .dvd_tready(dvd_tready), .dvs_tvalid(dvs_tvalid),
        .dvs_tready(dvs_tready), .dvd_tdata(dvd_tdata), .dvs_tdata(dvs_tdata),
        .div_unsigned(div_unsigned), .dout_tvalid(dout_tvalid), .dout_tdata(dout_tdata)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic uns);
        logic [31:0] q, r;
        if (uns) begin
            q = a / b;
            r = a % b;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {q, r};
    endfunction

    // One clock: record handshakes, advance, then step the divider-core model.
    task automatic tick();
        logic sa, sb;
        sa = resetn && dvd_tvalid && !dvd_tready;
        sb = resetn && dvs_tvalid && !dvs_tready;
        if (resetn && dvd_tvalid && dvd_tready) begin
            core_a = dvd_tdata; core_u = div_unsigned; have_a = 1'b1;
        end
        if (resetn && dvs_tvalid && dvs_tready) begin
            core_b = dvs_tdata; have_b = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if (sa) check("dvd_tvalid_held", dvd_tvalid, 1'b1);
        if (sb) check("dvs_tvalid_held", dvs_tvalid, 1'b1);
        dout_tvalid = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                dout_tvalid = 1'b1;
                dout_tdata  = core_res;
            end
        end
        if (have_a && have_b) begin
            core_res = div_ref(core_a, core_b, core_u);
            core_cnt = core_lat;
            have_a = 1'b0;
            have_b = 1'b0;
        end
    endtask

    task automatic core_clear();
        have_a = 1'b0; have_b = 1'b0; core_cnt = 0; dout_tvalid = 1'b0;
    endtask

    task automatic set_ready(input int k);
        case (rdy_mode)
            1: begin dvd_tready = (k == 1); dvs_tready = (k == 3); end
            2: begin dvd_tready = 1'b1; dvs_tready = (k > 4); end
            3: begin dvd_tready = 1'b1; dvs_tready = 1'b1; end
            default: begin
                dvd_tready = 1'($urandom_range(0, 1));
                dvs_tready = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    // end_mode: 0 = ack, 1 = flush, 2 = ack and flush together
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input int flush_at, input int end_mode, input int hold);
        logic [63:0] qr;
        logic [31:0] exp;
        bit flushed, prev_dout, done;
        qr  = div_ref(a, b, op[1]);
        exp = op[0] ? qr[31:0] : qr[63:32];
        check("idle_ready", req_ready, 1'b1);
        check("idle_busy", busy, 1'b0);
        req_valid = 1'b1; req_src1 = a; req_src2 = b; req_op = op;
        tick();
        req_valid = 1'b0; req_src1 = $urandom; req_src2 = $urandom; req_op = 2'($urandom);
        check("issue_busy", busy, 1'b1);
        check("issue_ready", req_ready, 1'b0);
        check("issue_dvd_tvalid", dvd_tvalid, 1'b1);
        check("issue_dvs_tvalid", dvs_tvalid, 1'b1);
        check("issue_dvd_tdata", dvd_tdata, a);
        check("issue_dvs_tdata", dvs_tdata, b);
        check("issue_unsigned", div_unsigned, op[1]);
        flushed = 1'b0; prev_dout = 1'b0; done = 1'b0;
        for (int k = 1; k <= 300 && !done; k++) begin
            if (res_valid) begin
                check("res_after_flush", flushed, 1'b0);
                check("res_latency", prev_dout, 1'b1);
                done = 1'b1;
            end else if (req_ready) begin
                check("idle_without_flush", flushed, 1'b1);
                done = 1'b1;
            end else begin
                if (rdy_mode == 1 && k == 2) check("stag_dvd_dropped", dvd_tvalid, 1'b0);
                if (rdy_mode == 1 && k == 3) check("stag_dvs_high", dvs_tvalid, 1'b1);
                if (rdy_mode == 1 && k == 4) check("stag_wait_dvs_low", dvs_tvalid, 1'b0);
                if (rdy_mode == 2 && k == 6) check("drain_dvs_low", dvs_tvalid, 1'b0);
                set_ready(k);
                flush = (k == flush_at);
                if (flush) flushed = 1'b1;
                prev_dout = dout_tvalid;
                tick();
                flush = 1'b0;
                if (flushed && prev_dout) check("idle_after_drop", req_ready, 1'b1);
            end
        end
        if (!done) check("txn_timeout", 1'b0, 1'b1);
        if (done && res_valid) begin
            last_res = res_data;
            check("res_data", res_data, exp);
            check("res_unsigned", div_unsigned, op[1]);
            for (int h = 0; h < hold; h++) begin
                tick();
                check("res_held_valid", res_valid, 1'b1);
                check("res_held_data", res_data, exp);
            end
            res_ack = (end_mode != 1);
            flush   = (end_mode != 0);
            tick();
            res_ack = 1'b0;
            flush   = 1'b0;
            check("post_res_valid", res_valid, 1'b0);
            check("post_res_ready", req_ready, 1'b1);
            check("post_res_busy", busy, 1'b0);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; req_valid = 1'b0; flush = 1'b0; res_ack = 1'b0;
        dvd_tready = 1'b0; dvs_tready = 1'b0;
        core_clear();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_dvd_tvalid", dvd_tvalid, 1'b0);
        check("rst_dvs_tvalid", dvs_tvalid, 1'b0);
        check("rst_dvd_tdata", dvd_tdata, 32'd0);
        check("rst_dvs_tdata", dvs_tdata, 32'd0);
        check("rst_unsigned", div_unsigned, 1'b0);
    endtask

    initial begin
        logic [31:0] a, b;
        req_src1 = 32'd0; req_src2 = 32'd0; req_op = 2'd0; dout_tdata = 64'd0;
        core_lat = 1; rdy_mode = 3; last_res = 32'd0;
        @(negedge clk);
        do_reset();
        check_reset_outputs();

        // flush together with a request is ignored
        req_valid = 1'b1; flush = 1'b1; req_src1 = 32'd5; req_src2 = 32'd1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_req_ready", req_ready, 1'b1);
        check("flush_req_busy", busy, 1'b0);

        rdy_mode = 3; core_lat = 3;
        run_txn(32'hFFFF_FFF9, 32'd2, 2'b00, 0, 0, 3);
        check("sdiv_value", last_res, 32'hFFFF_FFFD);
        run_txn(32'hFFFF_FFFF, 32'd16, 2'b11, 0, 0, 1);
        check("umod_value", last_res, 32'h0000_000F);

        rdy_mode = 1; core_lat = 2;
        run_txn(32'd1000, 32'd7, 2'b10, 0, 0, 0);
        check("stag_value", last_res, 32'd142);

        // flush in WAIT, then a fresh op must see its own result
        rdy_mode = 3; core_lat = 6;
        run_txn(32'd100, 32'd7, 2'b00, 2, 0, 0);
        core_lat = 2;
        run_txn(32'd90, 32'd9, 2'b01, 0, 2, 0);
        check("post_flush_value", last_res, 32'd0);

        // flush in ISSUE while the divisor channel stalls
        rdy_mode = 2; core_lat = 3;
        run_txn(32'd55, 32'd5, 2'b00, 2, 0, 0);

        // reset during WAIT, then a stale core output in IDLE
        rdy_mode = 3; core_lat = 20;
        req_valid = 1'b1; req_src1 = 32'd77; req_src2 = 32'd3; req_op = 2'b10;
        tick();
        req_valid = 1'b0; dvd_tready = 1'b1; dvs_tready = 1'b1;
        tick();
        check("wait_busy", busy, 1'b1);
        resetn = 1'b0;
        core_clear();
        tick();
        check_reset_outputs();
        resetn = 1'b1;
        dout_tvalid = 1'b1; dout_tdata = 64'hDEAD_BEEF_1234_5678;
        tick();
        check("stale_res_valid", res_valid, 1'b0);
        check("stale_ready", req_ready, 1'b1);
        check("stale_busy", busy, 1'b0);

        rdy_mode = 0;
        for (int t = 0; t < 60; t++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            core_lat = $urandom_range(1, 6);
            run_txn(a, b, 2'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0,
                    $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
